// File: rtl/lutram_fifo.sv
// Show-ahead synchronous FIFO on an asynchronous-read distributed RAM.
// Status flags are decoded from the registered occupancy only.
module lutram_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned AF_LEVEL  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [ADDR_BITS:0]   level,
  output logic                 almost_full
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FullLvl = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AfLvl   = (ADDR_BITS + 1)'(AF_LEVEL);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 push, pop;

  assign wr_ready    = (level_q != FullLvl);
  assign rd_valid    = (level_q != '0);
  assign almost_full = (level_q >= AfLvl);
  assign level       = level_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  // RAM contents are not reset; a write during clear is harmless since pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
